// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/PC-enable generation and HLT drain sequencing.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           ID_rs,
    input  logic [3:0]           ID_rt,
    input  logic                 ID_uses_rt,
    input  logic                 ID_Halt,
    input  logic                 ID_BranchTaken,
    input  logic                 EX_MemRead,
    input  logic [3:0]           EX_rd,
    input  logic                 icache_miss,
    input  logic                 dcache_miss,
    output logic                 pc_wen,
    output logic                 IFID_stall,
    output logic                 IFID_flush,
    output logic                 IDEX_stall,
    output logic                 IDEX_flush,
    output logic                 EXMEM_stall,
    output logic                 MEMWB_stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] cnt_loaduse,
    output logic [CNT_WIDTH-1:0] cnt_freeze,
    output logic [CNT_WIDTH-1:0] cnt_flush,
`endif
    output logic                 halted
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_cnt_nxt;
    logic          load_use;

    assign load_use = EX_MemRead && (EX_rd != 4'd0) &&
                      ((EX_rd == ID_rs) || (ID_uses_rt && (EX_rd == ID_rt)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= DRAIN_CYCLES[DW-1:0];
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halted    <= (state_nxt == HALTED);
        end
    end

    always_comb begin
        pc_wen        = 1'b0;
        IFID_stall    = 1'b0;
        IFID_flush    = 1'b0;
        IDEX_stall    = 1'b0;
        IDEX_flush    = 1'b0;
        EXMEM_stall   = 1'b0;
        MEMWB_stall   = 1'b0;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;

        if (!rst) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (dcache_miss) begin
                        IFID_stall  = 1'b1;
                        IDEX_stall  = 1'b1;
                        EXMEM_stall = 1'b1;
                        MEMWB_stall = 1'b1;
                    end else if (load_use) begin
                        IFID_stall = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (ID_Halt) begin
                        // HLT moves on into ID/EX; nothing younger is fetched behind it
                        IFID_flush    = 1'b1;
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_CYCLES[DW-1:0];
                    end else if (icache_miss) begin
                        IFID_flush = 1'b1;
                    end else if (ID_BranchTaken) begin
                        pc_wen     = 1'b1;
                        IFID_flush = 1'b1;
                    end else begin
                        pc_wen = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcache_miss) begin
                        IFID_stall  = 1'b1;
                        IDEX_stall  = 1'b1;
                        EXMEM_stall = 1'b1;
                        MEMWB_stall = 1'b1;
                    end else begin
                        if (load_use) begin
                            IFID_stall = 1'b1;
                            IDEX_flush = 1'b1;
                        end else begin
                            IFID_flush = 1'b1;
                        end
                        // The last older instruction leaves WB on the cycle the count hits zero
                        if (drain_cnt <= DW'(1)) begin
                            state_nxt     = HALTED;
                            drain_cnt_nxt = '0;
                        end else begin
                            drain_cnt_nxt = drain_cnt - DW'(1);
                        end
                    end
                end
                HALTED: begin
                    IFID_stall  = 1'b1;
                    IDEX_stall  = 1'b1;
                    EXMEM_stall = 1'b1;
                    MEMWB_stall = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic freeze_act;
    logic loaduse_act;
    logic branch_act;

    assign freeze_act  = rst && (state != HALTED) && dcache_miss;
    assign loaduse_act = rst && (state != HALTED) && !dcache_miss && load_use;
    assign branch_act  = rst && (state == RUN) && !dcache_miss && !load_use &&
                         !ID_Halt && !icache_miss && ID_BranchTaken;

    // Saturating event counters; the activity terms already exclude HALTED
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_loaduse <= '0;
            cnt_freeze  <= '0;
            cnt_flush   <= '0;
        end else begin
            if (loaduse_act && (cnt_loaduse != '1)) cnt_loaduse <= cnt_loaduse + 1'b1;
            if (freeze_act && (cnt_freeze != '1))   cnt_freeze  <= cnt_freeze + 1'b1;
            if (branch_act && (cnt_flush != '1))    cnt_flush   <= cnt_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard testbench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Define HAZARD_PERF_CNT_EN to also check counters.
module tb_hazard_ctrl;

    // Expected vector bit order: {pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_stall, halted}
    localparam logic [7:0] E_RESET  = 8'b0010_1000;
    localparam logic [7:0] E_RUN    = 8'b1000_0000;
    localparam logic [7:0] E_LU     = 8'b0100_1000;
    localparam logic [7:0] E_FRZ    = 8'b0101_0110;
    localparam logic [7:0] E_IMISS  = 8'b0010_0000;
    localparam logic [7:0] E_BR     = 8'b1010_0000;
    localparam logic [7:0] E_DRN    = 8'b0010_0000;
    localparam logic [7:0] E_HLTD   = 8'b0101_0111;
    localparam logic [7:0] E_RST_HL = 8'b0010_1001;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ID_rs, ID_rt, EX_rd;
    logic       ID_uses_rt, ID_Halt, ID_BranchTaken, EX_MemRead;
    logic       icache_miss, dcache_miss;
    logic       pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush;
    logic       EXMEM_stall, MEMWB_stall, halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] cnt_loaduse, cnt_freeze, cnt_flush;
`endif

    sb_item_t sb_q[$];
    int       errors = 0;
    int       checks = 0;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_uses_rt     (ID_uses_rt),
        .ID_Halt        (ID_Halt),
        .ID_BranchTaken (ID_BranchTaken),
        .EX_MemRead     (EX_MemRead),
        .EX_rd          (EX_rd),
        .icache_miss    (icache_miss),
        .dcache_miss    (dcache_miss),
        .pc_wen         (pc_wen),
        .IFID_stall     (IFID_stall),
        .IFID_flush     (IFID_flush),
        .IDEX_stall     (IDEX_stall),
        .IDEX_flush     (IDEX_flush),
        .EXMEM_stall    (EXMEM_stall),
        .MEMWB_stall    (MEMWB_stall),
`ifdef HAZARD_PERF_CNT_EN
        .cnt_loaduse    (cnt_loaduse),
        .cnt_freeze     (cnt_freeze),
        .cnt_flush      (cnt_flush),
`endif
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected response, advance to just past the next edge
    task automatic applyStimulus(input string name, input logic r,
                                 input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                                 input logic hlt, input logic br, input logic mr,
                                 input logic [3:0] rd, input logic im, input logic dm,
                                 input logic [7:0] exp);
        sb_item_t it;
        rst            = r;
        ID_rs          = rs;
        ID_rt          = rt;
        ID_uses_rt     = urt;
        ID_Halt        = hlt;
        ID_BranchTaken = br;
        EX_MemRead     = mr;
        EX_rd          = rd;
        icache_miss    = im;
        dcache_miss    = dm;
        it.name = name;
        it.exp  = exp;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input logic [7:0] exp);
        applyStimulus(name, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, exp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            checkOutput(it.name,
                        {8'd0, pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
                         EXMEM_stall, MEMWB_stall, halted},
                        {8'd0, it.exp});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        {ID_rs, ID_rt, EX_rd} = '0;
        {ID_uses_rt, ID_Halt, ID_BranchTaken, EX_MemRead, icache_miss, dcache_miss} = '0;
        @(posedge clk);
        #1;

        applyStimulus("reset1", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_RESET);
        applyStimulus("reset2", 1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, E_RESET);
        idle("run_idle", E_RUN);

        applyStimulus("lu_rs",       1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        applyStimulus("lu_rd0",      1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, E_RUN);
        applyStimulus("lu_rt_unused",1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, E_RUN);
        applyStimulus("lu_rt_used",  1'b1, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        applyStimulus("lu_no_load",  1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, E_RUN);

        applyStimulus("br_vs_lu",    1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        applyStimulus("br_taken",    1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, E_BR);
        applyStimulus("imiss",       1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, E_IMISS);
        applyStimulus("imiss_vs_br", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, E_IMISS);
        applyStimulus("lu_vs_imiss", 1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, E_LU);

        applyStimulus("pre_frz_rst", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_RESET);
        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("freeze%0d", i), 1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,
                          1'b1, 1'b1, E_FRZ);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("cnt_freeze",  cnt_freeze,  16'd5);
        checkOutput("cnt_loaduse", cnt_loaduse, 16'd0);
        checkOutput("cnt_flush",   cnt_flush,   16'd0);
`endif
        idle("post_frz", E_RUN);

        applyStimulus("hlt_entry", 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_DRN);
        idle("drain1", E_DRN);
        applyStimulus("drain_frz", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, E_FRZ);
        idle("drain2", E_DRN);
        idle("drain3", E_DRN);
        idle("halted1", E_HLTD);
        applyStimulus("halted_br", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, E_HLTD);
        applyStimulus("halt_rst", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_RST_HL);
        idle("after_halt_rst", E_RUN);

        applyStimulus("hlt2_entry", 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_DRN);
        idle("hlt2_drain1", E_DRN);
        applyStimulus("mid_rst", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_RESET);
        idle("mid_rst_run", E_RUN);

        applyStimulus("hlt3_entry", 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_DRN);
        idle("hlt3_drain1", E_DRN);
        idle("hlt3_drain2", E_DRN);
        idle("hlt3_drain3", E_DRN);
        idle("hlt3_halted", E_HLTD);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
